// File: rtl/seq_divider_if.sv
// Divide-request interface between the ALU control (master) and the
// sequential divider (slave): clock enable, operands in, results and
// handshake out.
interface seq_divider_if #(
    parameter int WIDTH = 16
);
    logic             clken;
    logic             start;
    logic [WIDTH-1:0] numer;
    logic [WIDTH-1:0] denom;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    modport master (
        output clken, start, numer, denom,
        input  quotient, remainder, div_by_zero, busy, done
    );

    modport slave (
        input  clken, start, numer, denom,
        output quotient, remainder, div_by_zero, busy, done
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle signed integer divider. Restoring shift-subtract on the
// operand magnitudes, one quotient bit per enabled clock, followed by a
// sign-fixup cycle. Fixed latency independent of the operands.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic clock,
    input  logic reset,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem_r;      // partial remainder, one bit wider than |d|
    logic [WIDTH-1:0] quo_r;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] den_r;      // |denom|
    logic             neg_q;      // quotient must be negated
    logic             neg_r;      // remainder must be negated (sign of numer)
    logic             dbz_r;      // captured denom == 0

    logic [WIDTH-1:0] abs_numer;
    logic [WIDTH-1:0] abs_denom;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1)
    // when read as unsigned, which is exactly what the datapath wants.
    assign abs_numer = bus.numer[WIDTH-1] ? -bus.numer : bus.numer;
    assign abs_denom = bus.denom[WIDTH-1] ? -bus.denom : bus.denom;
    assign rem_shift = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};

    // One restoring step: trial-subtract |d| from the shifted remainder.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        rem_next = rem_shift;
        quo_next = {quo_r[WIDTH-2:0], 1'b0};
        if (rem_shift >= {1'b0, den_r}) begin
            rem_next    = rem_shift - {1'b0, den_r};
            quo_next[0] = 1'b1;
        end
    end

    // Control FSM with the datapath and registered results.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state           <= IDLE;
            count           <= '0;
            rem_r           <= '0;
            quo_r           <= '0;
            den_r           <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            dbz_r           <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else if (bus.clken) begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        rem_r    <= '0;
                        quo_r    <= abs_numer;
                        den_r    <= abs_denom;
                        neg_r    <= bus.numer[WIDTH-1];
                        neg_q    <= bus.numer[WIDTH-1] ^ bus.denom[WIDTH-1];
                        dbz_r    <= (bus.denom == '0);
                        count    <= CW'(WIDTH);
                        bus.busy <= 1'b1;
                        state    <= DIV;
                    end
                end
                DIV: begin
                    rem_r <= rem_next;
                    quo_r <= quo_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // With |d| = 0 every trial subtract succeeds, so the raw
                    // quotient is all ones and the raw remainder is |numer|;
                    // force the quotient so its sign fixup cannot disturb it.
                    if (dbz_r) begin
                        bus.quotient <= '1;
                    end else if (neg_q) begin
                        bus.quotient <= -quo_r;
                    end else begin
                        bus.quotient <= quo_r;
                    end
                    bus.remainder   <= neg_r ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
                    bus.div_by_zero <= dbz_r;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, handshake corner
// cases, then corner-biased random operands against a signed reference.
module tb_seq_divider;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: Verilog signed / and % on sign-extended operands, truncated.
    function automatic exp_t model(input logic [W-1:0] n, input logic [W-1:0] d);
        exp_t e;
        int   ni, di, qi, ri;
        if (d == '0) begin
            e.q   = '1;
            e.r   = n;
            e.dbz = 1'b1;
        end else begin
            ni    = int'($signed(n));
            di    = int'($signed(d));
            qi    = ni / di;
            ri    = ni % di;
            e.q   = qi[W-1:0];
            e.r   = ri[W-1:0];
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 9))
            0:       v = 16'h0000;
            1:       v = 16'h0001;
            2:       v = 16'hFFFF;
            3:       v = 16'h8000;
            4:       v = 16'h7FFF;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Issue one division from a negedge, optionally pulsing stray starts and
    // holding clken low, then check latency, busy length and the results.
    task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, input exp_t e,
                          input int g1, input int g2, input int fz_start, input int fz_len);
        int   edges;
        int   busy_cnt;
        bit   seen;
        exp_t got;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.numer = n;
        bus.denom = d;
        bus.clken = 1'b1;
        edges     = 0;
        busy_cnt  = 0;
        seen      = 1'b0;
        while (!seen && edges < 200) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (bus.busy) busy_cnt++;
            if (bus.done) seen = 1'b1;
            bus.start = ((edges + 1) == g1) || ((edges + 1) == g2);
            bus.numer = W'($urandom);
            bus.denom = W'($urandom);
            bus.clken = !(((edges + 1) >= fz_start) && ((edges + 1) < fz_start + fz_len));
        end
        check("latency", edges, 18 + fz_len);
        check("busy_len", busy_cnt, 17 + fz_len);
        got = sb.pop_front();
        check("quotient", bus.quotient, got.q);
        check("remainder", bus.remainder, got.r);
        check("div_by_zero", bus.div_by_zero, got.dbz);
    endtask

    initial begin
        logic [W-1:0] corners [6];
        logic [W-1:0] rn, rd;
        corners = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0007};

        bus.clken = 1'b0;
        bus.start = 1'b0;
        bus.numer = '0;
        bus.denom = '0;

        // Reset state
        #1 reset = 1'b1;
        #1;
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        bus.clken = 1'b1;
        @(negedge clock);

        // Sign combinations
        run_op(16'd100, 16'd7, '{16'd14, 16'd2, 1'b0}, 0, 0, 0, 0);
        run_op(-16'd100, 16'd7, '{16'hFFF2, 16'hFFFE, 1'b0}, 0, 0, 0, 0);
        run_op(16'd100, -16'd7, '{16'hFFF2, 16'd2, 1'b0}, 0, 0, 0, 0);
        run_op(-16'd100, -16'd7, '{16'd14, 16'hFFFE, 1'b0}, 0, 0, 0, 0);

        // Divide by zero, then a normal op clears the flag
        run_op(16'd7, 16'd0, '{16'hFFFF, 16'd7, 1'b1}, 0, 0, 0, 0);
        run_op(16'd9, 16'd3, '{16'd3, 16'd0, 1'b0}, 0, 0, 0, 0);

        // clken low while done is high keeps done and results frozen
        bus.clken = 1'b0;
        repeat (3) @(negedge clock);
        check("frozen_done", bus.done, 1);
        check("frozen_quotient", bus.quotient, 3);
        bus.clken = 1'b1;
        @(negedge clock);
        check("done_cleared", bus.done, 0);
        check("held_quotient", bus.quotient, 3);

        // Overflow and most-negative dividend
        run_op(16'h8000, 16'hFFFF, '{16'h8000, 16'h0000, 1'b0}, 0, 0, 0, 0);
        run_op(16'h8000, 16'h0001, '{16'h8000, 16'h0000, 1'b0}, 0, 0, 0, 0);

        // Stray starts at edges 3 and 10 are ignored
        run_op(16'd100, 16'd7, '{16'd14, 16'd2, 1'b0}, 3, 10, 0, 0);
        // Five frozen cycles mid-division push done to edge 23
        run_op(16'd100, 16'd7, '{16'd14, 16'd2, 1'b0}, 0, 0, 6, 5);

        // Asynchronous reset at edge 8 of a division
        bus.numer = 16'd1000;
        bus.denom = 16'd3;
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (6) begin
            @(posedge clock);
            @(negedge clock);
        end
        check("busy_before_reset", bus.busy, 1);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_quotient", bus.quotient, 0);
        check("mid_rst_remainder", bus.remainder, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_op(16'd1000, 16'd3, '{16'd333, 16'd1, 1'b0}, 0, 0, 0, 0);

        // Every pair of corner operands
        foreach (corners[i]) begin
            foreach (corners[j]) begin
                run_op(corners[i], corners[j], model(corners[i], corners[j]), 0, 0, 0, 0);
            end
        end

        // Corner-biased random pairs
        for (int k = 0; k < 1500; k++) begin
            rn = pick();
            rd = pick();
            run_op(rn, rd, model(rn, rd), 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
